serial_frame_rx_ctrl: RTL

Receive-side frame controller for the serial-to-parallel datapath. It is armed by a start request and waits for a start bit on the serial line. It then counts and shifts exactly framesize data bits into a WIDTH-bit parallel register, and holds the result with a complete flag until the consumer acknowledges. It replaces free-running counter/compare glue with an explicit sequencer. Abort and timeout handling are included.

---
 rtl/serial_frame_rx_ctrl_if.sv | 27 ++
 rtl/serial_frame_rx_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/serial_frame_rx_ctrl_if.sv
// Handshake and data bundle for serial_frame_rx_ctrl.
// The consumer side drives master; the receiver itself binds to slave.
interface serial_frame_rx_ctrl_if #(
  parameter int WIDTH            = 8,
  parameter int FRAME_SIZE_WIDTH = 8
);
  logic                        enable;
  logic                        start;
  logic [FRAME_SIZE_WIDTH-1:0] framesize;
  logic                        serial;
  logic                        ack;
  logic [WIDTH-1:0]            parallel;
  logic [FRAME_SIZE_WIDTH-1:0] bit_count;
  logic                        busy;
  logic                        complete;
  logic                        timeout;

  modport master (
    output enable, start, framesize, serial, ack,
    input  parallel, bit_count, busy, complete, timeout
  );

  modport slave (
    input  enable, start, framesize, serial, ack,
    output parallel, bit_count, busy, complete, timeout
  );
endinterface

// File: rtl/serial_frame_rx_ctrl.sv
// Serial-to-parallel frame receiver: arm, wait for start bit, shift framesize bits, hold until ack.
// Optional start-bit timeout is compiled in with `define RX_TIMEOUT_EN.
module serial_frame_rx_ctrl #(
  parameter int WIDTH            = 8,
  parameter int FRAME_SIZE_WIDTH = 8,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input logic                  clk,
  input logic                  rst,
  serial_frame_rx_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] RECEIVE    = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]                  state;
  logic [WIDTH-1:0]            parallel_q;
  logic [FRAME_SIZE_WIDTH-1:0] count_q;
  logic [FRAME_SIZE_WIDTH-1:0] size_q;
  logic                        busy_q;
  logic                        complete_q;
  logic                        timeout_q;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`endif

  assign bus.parallel  = parallel_q;
  assign bus.bit_count = count_q;
  assign bus.busy      = busy_q;
  assign bus.complete  = complete_q;
  assign bus.timeout   = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      parallel_q <= '0;
      count_q    <= '0;
      size_q     <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef RX_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable && bus.start && (bus.framesize != '0)) begin
            size_q  <= bus.framesize;
            count_q <= '0;
            busy_q  <= 1'b1;
            state   <= WAIT_START;
`ifdef RX_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT_START: begin
          // Only a clean 0 counts as a start bit; 1/X/Z keep waiting.
          if (!bus.enable) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else if (bus.serial == 1'b0) begin
            state <= RECEIVE;
`ifdef RX_TIMEOUT_EN
          end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        RECEIVE: begin
          if (!bus.enable) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else begin
            parallel_q <= {parallel_q[WIDTH-2:0], bus.serial};
            count_q    <= count_q + 1'b1;
            if (count_q == size_q - 1'b1) begin
              state      <= DONE;
              complete_q <= 1'b1;
            end
          end
        end
        default: begin
          if (!bus.enable) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            count_q    <= '0;
          end else if (bus.ack) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
